// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared helpers for deriving the divider and counter widths
package tick_gen_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((64'(1) << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen_stage.sv
// tick_gen_stage: mod-N counter that advances on I_INC and flags its wrap as a carry
module tick_gen_stage
  import tick_gen_pkg::*;
#(
  parameter int N = 10
) (
  input  logic I_CLK,
  input  logic I_RST,
  input  logic I_CLEAR_EN,
  input  logic I_INC,
  output logic O_CARRY
);

  localparam int W = cnt_w(N);

  logic [W-1:0] cnt_q, cnt_d;

  // carry is same-edge so the whole cascade wraps together; clear discards partial phase
  always_comb begin
    O_CARRY = I_INC & (cnt_q == W'(N - 1));
    cnt_d   = (I_CLEAR_EN | O_CARRY) ? '0 : I_INC ? cnt_q + W'(1) : cnt_q;
  end

  // counter state
  always_ff @(posedge I_CLK) begin
    if (I_RST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tick_gen.sv
// tick_gen: prescaler plus cascaded decade stages producing phase-aligned one-cycle tick enables
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 16_000_000,
  parameter int BASE_TICK_HZ = 1000,
  parameter int N_STAGES     = 4,
  parameter int STAGE_RATIO  = 10
) (
  input  logic                I_CLK,
  input  logic                I_RST,
  input  logic                I_START_EN,
  input  logic                I_CLEAR_EN,
  output logic [N_STAGES-1:0] O_TICK,
  output logic                O_RUNNING
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BASE_TICK_HZ);

  if (CLK_FREQ_HZ % BASE_TICK_HZ != 0) begin : g_chk_mult
    $error("tick_gen: CLK_FREQ_HZ must be a multiple of BASE_TICK_HZ");
  end
  if (DIV < 2) begin : g_chk_div
    $error("tick_gen: DIV must be at least 2");
  end
  if (STAGE_RATIO < 2) begin : g_chk_ratio
    $error("tick_gen: STAGE_RATIO must be at least 2");
  end
  if (N_STAGES < 1) begin : g_chk_stages
    $error("tick_gen: N_STAGES must be at least 1");
  end

  logic [N_STAGES-1:0] carry, tick_d, tick_q;
  logic                inc, running_d, running_q;

  tick_gen_stage #(.N(DIV)) u_pre (
    .I_CLK      (I_CLK),
    .I_RST      (I_RST),
    .I_CLEAR_EN (I_CLEAR_EN),
    .I_INC      (inc),
    .O_CARRY    (carry[0])
  );

  for (genvar i = 1; i < N_STAGES; i++) begin : g_stage
    tick_gen_stage #(.N(STAGE_RATIO)) u_stage (
      .I_CLK      (I_CLK),
      .I_RST      (I_RST),
      .I_CLEAR_EN (I_CLEAR_EN),
      .I_INC      (carry[i-1]),
      .O_CARRY    (carry[i])
    );
  end

  // clear outranks start; carries are already zero while stopped or clearing
  always_comb begin
    inc       = I_START_EN & ~I_CLEAR_EN;
    running_d = inc;
    tick_d    = carry;
  end

  // register ticks and run status so no input reaches an output combinationally
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      tick_q    <= '0;
      running_q <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

  assign O_TICK    = tick_q;
  assign O_RUNNING = running_q;

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed checks of tick cascade, stop/resume, clear and reset with DIV=4, ratio 3
module tb_tick_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] tick;
  logic       running;
  int         tests = 0;
  int         fails = 0;

  tick_gen #(
    .CLK_FREQ_HZ  (100),
    .BASE_TICK_HZ (25),
    .N_STAGES     (3),
    .STAGE_RATIO  (3)
  ) dut (
    .I_CLK      (clk),
    .I_RST      (rst),
    .I_START_EN (start),
    .I_CLEAR_EN (clear),
    .O_TICK     (tick),
    .O_RUNNING  (running)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic s, input logic c,
                      input logic [2:0] exp_tick, input logic exp_run, input string tag);
    rst   = r;
    start = s;
    clear = c;
    @(posedge clk);
    #1;
    tests++;
    assert (tick === exp_tick) else begin
      fails++;
      $error("FAIL %s tick got %b want %b", tag, tick, exp_tick);
    end
    tests++;
    assert (running === exp_run) else begin
      fails++;
      $error("FAIL %s running got %b want %b", tag, running, exp_run);
    end
  endtask

  task automatic run_from_zero(input int n, input string tag);
    for (int k = 1; k <= n; k++)
      step(1'b0, 1'b1, 1'b0, {k % 36 == 0, k % 12 == 0, k % 4 == 0}, 1'b1, tag);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "clear");
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, "reset");
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, "reset_start");
    run_from_zero(40, "free_run");
    do_clear();
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, "pre_stop");
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, "stopped");
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, "resume_3");
    step(1'b0, 1'b1, 1'b0, 3'b001, 1'b1, "resume_tick");
    do_clear();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, "pre_wrap_stop");
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, "stop_at_wrap");
    step(1'b0, 1'b1, 1'b0, 3'b001, 1'b1, "wrap_after_resume");
    do_clear();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, "pre_clear");
    step(1'b0, 1'b1, 1'b1, 3'b000, 1'b0, "clear_with_start");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, "post_clear");
    step(1'b0, 1'b1, 1'b0, 3'b001, 1'b1, "post_clear_tick");
    do_clear();
    for (int k = 1; k <= 10; k++) step(1'b0, 1'b1, 1'b0, {2'b00, k % 4 == 0}, 1'b1, "pre_reset");
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, "reset_mid");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, "post_reset");
    step(1'b0, 1'b1, 1'b0, 3'b001, 1'b1, "post_reset_tick");
    do_clear();
    run_from_zero(72, "top_wrap");
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, "final_stop");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
